// File: rtl/servo_pwm_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pkg
//  Description : Shared constants, count type, FSM state encoding and helper
//                function for the servo PWM generator/decoder pair.
//  Revision    : 1.0  initial release
// ============================================================================
package servo_pkg;

  // Default timing at 50 MHz, shared with the generator.
  localparam int unsigned C_FRAME_CYCLES   = 1000000;  // 20 ms frame
  localparam int unsigned C_LOCK_CYCLES    = 50000;    // 1 ms  -> locked
  localparam int unsigned C_UNLOCK_CYCLES  = 100000;   // 2 ms  -> unlocked
  localparam int unsigned C_TOL_CYCLES     = 5000;     // +/-0.1 ms, inclusive
  localparam int unsigned C_MIN_CYCLES     = 25000;    // shortest real pulse
  localparam int unsigned C_MAX_CYCLES     = 125000;   // stuck-high limit
  localparam int unsigned C_TIMEOUT_CYCLES = 2000000;  // two frames

  typedef logic [19:0] count_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_RISE = 3'd1,
    HIGH      = 3'd2,
    WAIT_FALL = 3'd3,
    EVAL      = 3'd4
  } state_t;

  // Unsigned distance: larger operand minus smaller, never wraps.
  function automatic count_t abs_diff(input count_t a, input count_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pwm_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pwm_decoder_if
//  Description : Line input and decoded-result bundle of the servo PWM
//                decoder.
//                pwm_in      raw PWM line (async to clk)
//                width       high time of last completed pulse, clk cycles
//                width_valid strobe, width updated
//                locked      last valid decoded command
//                cmd_valid   strobe, valid command decoded
//                error       strobe, pulse out of spec
//                timeout     level, no rising edge for too long
//  Revision    : 1.0  initial release
// ============================================================================
interface servo_pwm_decoder_if;
  import servo_pkg::*;

  logic   pwm_in;
  count_t width;
  logic   width_valid;
  logic   locked;
  logic   cmd_valid;
  logic   error;
  logic   timeout;

  // Source side: drives the line, observes the decode.
  modport master (
    output pwm_in,
    input  width, width_valid, locked, cmd_valid, error, timeout
  );

  // Decoder side.
  modport slave (
    input  pwm_in,
    output width, width_valid, locked, cmd_valid, error, timeout
  );
endinterface
`default_nettype wire

// File: rtl/servo_pwm_decoder_filter.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_input_filter
//  Description : 2-FF synchronizer followed by a run-length glitch filter.
//                The filtered level changes only after FILTER_LEN
//                consecutive synchronized samples disagree with it, so both
//                edges see the same latency.
//                clk/rst  clock, async active-high reset
//                pwm_in   raw line
//                f        filtered level
//                rise     one-cycle strobe, f went 0->1
//                fall     one-cycle strobe, f went 1->0
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_input_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic f,
  output logic rise,
  output logic fall
);

  localparam int unsigned RW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [RW-1:0] C_RUN_LAST = RW'(FILTER_LEN - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_f;
  logic          r_f_d;
  logic [RW-1:0] r_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_f   <= 1'b0;
      r_f_d <= 1'b0;
      r_run <= '0;
    end else begin
      r_s1  <= pwm_in;
      r_s2  <= r_s1;
      r_f_d <= r_f;
      if (r_s2 != r_f) begin
        if (r_run == C_RUN_LAST) begin
          r_f   <= r_s2;
          r_run <= '0;
        end else begin
          r_run <= r_run + 1'b1;
        end
      end else begin
        // Any sample agreeing with f breaks the run.
        r_run <= '0;
      end
    end
  end

  assign f    = r_f;
  assign rise = r_f & ~r_f_d;
  assign fall = ~r_f & r_f_d;

endmodule
`default_nettype wire

// File: rtl/servo_pwm_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pwm_decoder
//  Description : Measures the high time of a servo PWM line and decodes it
//                into a lock/unlock command; flags malformed pulses and a
//                dead line.
//                clk  50 MHz system clock
//                rst  asynchronous active-high reset
//                bus  servo_pwm_decoder_if.slave (pwm_in in; width,
//                     width_valid, locked, cmd_valid, error, timeout out)
//  Revision    : 1.0  initial release
// ============================================================================
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES    = C_LOCK_CYCLES,
  parameter int unsigned UNLOCK_CYCLES  = C_UNLOCK_CYCLES,
  parameter int unsigned TOL_CYCLES     = C_TOL_CYCLES,
  parameter int unsigned MIN_CYCLES     = C_MIN_CYCLES,
  parameter int unsigned MAX_CYCLES     = C_MAX_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = C_TIMEOUT_CYCLES,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic               clk,
  input  logic               rst,
  servo_pwm_decoder_if.slave bus
);

  localparam count_t C_LOCK   = count_t'(LOCK_CYCLES);
  localparam count_t C_UNLOCK = count_t'(UNLOCK_CYCLES);
  localparam count_t C_TOL    = count_t'(TOL_CYCLES);
  localparam count_t C_MIN    = count_t'(MIN_CYCLES);
  localparam count_t C_MAX    = count_t'(MAX_CYCLES);
  // After reset, f is not trustworthy until the synchronizer and filter have
  // seen the real line; IDLE waits this long before looking for a low level.
  localparam count_t C_SETTLE = count_t'(FILTER_LEN + 3);

  localparam int unsigned PW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] C_TIMEOUT = PW'(TIMEOUT_CYCLES);

  logic w_f;
  logic w_rise;
  logic w_fall;

  pwm_input_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (bus.pwm_in),
    .f      (w_f),
    .rise   (w_rise),
    .fall   (w_fall)
  );

  state_t        r_state;
  state_t        w_state_nxt;
  count_t        r_hcnt;
  count_t        w_hcnt_nxt;
  count_t        r_width;
  logic          r_width_valid;
  logic          r_cmd_valid;
  logic          r_error;
  logic          r_locked;
  logic          w_wv;
  logic          w_cmd;
  logic          w_err;
  logic          w_locked_nxt;
  logic [PW-1:0] r_pcnt;

  // State and high-time counter. In IDLE, hcnt doubles as the settle timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_hcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_hcnt_nxt   = r_hcnt;
    w_wv         = 1'b0;
    w_cmd        = 1'b0;
    w_err        = 1'b0;
    w_locked_nxt = r_locked;
    case (r_state)
      IDLE: begin
        // A pulse already high when we come out of reset is skipped.
        if (r_hcnt != C_SETTLE) w_hcnt_nxt = r_hcnt + 1'b1;
        else if (!w_f)          w_state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (w_rise) begin
          w_hcnt_nxt  = count_t'(1);
          w_state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (w_fall) begin
          w_state_nxt = EVAL;
        end else if (r_hcnt == C_MAX) begin
          w_err       = 1'b1;
          w_state_nxt = WAIT_FALL;
        end else begin
          w_hcnt_nxt = r_hcnt + 1'b1;
        end
      end
      WAIT_FALL: begin
        if (w_fall) w_state_nxt = WAIT_RISE;
      end
      EVAL: begin
        w_wv        = 1'b1;
        w_state_nxt = WAIT_RISE;
        if (r_hcnt < C_MIN) begin
          w_err = 1'b1;
        end else if (abs_diff(r_hcnt, C_LOCK) <= C_TOL) begin
          w_cmd        = 1'b1;
          w_locked_nxt = 1'b1;
        end else if (abs_diff(r_hcnt, C_UNLOCK) <= C_TOL) begin
          w_cmd        = 1'b1;
          w_locked_nxt = 1'b0;
        end else begin
          w_err = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_width       <= '0;
      r_width_valid <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_error       <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      if (w_wv) r_width <= r_hcnt;
      r_width_valid <= w_wv;
      r_cmd_valid   <= w_cmd;
      r_error       <= w_err;
      r_locked      <= w_locked_nxt;
    end
  end

  // Dead-line detector: rise wins over saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_pcnt <= '0;
    else if (w_rise)             r_pcnt <= '0;
    else if (r_pcnt != C_TIMEOUT) r_pcnt <= r_pcnt + 1'b1;
  end

  assign bus.width       = r_width;
  assign bus.width_valid = r_width_valid;
  assign bus.cmd_valid   = r_cmd_valid;
  assign bus.error       = r_error;
  assign bus.locked      = r_locked;
  assign bus.timeout     = (r_pcnt == C_TIMEOUT);

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo_pwm_decoder
//  Description : Self-checking bench for servo_pwm_decoder with scaled-down
//                timing; expected decode results come from a pulse-level
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_servo_pwm_decoder;
  import servo_pkg::*;

  localparam int unsigned T_LOCK   = 500;
  localparam int unsigned T_UNLOCK = 1000;
  localparam int unsigned T_TOL    = 50;
  localparam int unsigned T_MIN    = 250;
  localparam int unsigned T_MAX    = 1250;
  localparam int unsigned T_TO     = 4000;
  localparam int unsigned T_FLEN   = 4;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  int n_wv = 0, n_cmd = 0, n_err = 0;
  int last_err_cyc = 0;
  int rise_cyc = 0;

  int s_wv, s_cmd, s_err;
  int e_wv, e_cmd, e_err;
  int exp_width, exp_locked;

  servo_pwm_decoder_if bus ();

  servo_pwm_decoder #(
    .LOCK_CYCLES    (T_LOCK),
    .UNLOCK_CYCLES  (T_UNLOCK),
    .TOL_CYCLES     (T_TOL),
    .MIN_CYCLES     (T_MIN),
    .MAX_CYCLES     (T_MAX),
    .TIMEOUT_CYCLES (T_TO),
    .FILTER_LEN     (T_FLEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      n_wv  <= n_wv  + int'(bus.width_valid);
      n_cmd <= n_cmd + int'(bus.cmd_valid);
      n_err <= n_err + int'(bus.error);
      if (bus.error) last_err_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive the line to v for n clock periods.
  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (v && !bus.pwm_in) rise_cyc = cyc + 1;
      bus.pwm_in = v;
    end
  endtask

  task automatic snap();
    s_wv  = n_wv;
    s_cmd = n_cmd;
    s_err = n_err;
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Pulse-level reference: what one clean high pulse of n cycles produces.
  task automatic model(input int n);
    e_wv = 0; e_cmd = 0; e_err = 0;
    if (n > int'(T_MAX)) begin
      e_err = 1;
    end else begin
      e_wv = 1;
      exp_width = n;
      if (n >= int'(T_MIN) && absd(n, T_LOCK) <= int'(T_TOL)) begin
        e_cmd = 1; exp_locked = 1;
      end else if (n >= int'(T_MIN) && absd(n, T_UNLOCK) <= int'(T_TOL)) begin
        e_cmd = 1; exp_locked = 0;
      end else begin
        e_err = 1;
      end
    end
  endtask

  task automatic verify(input string tag);
    check({tag, "_width_valid"}, n_wv - s_wv, e_wv);
    check({tag, "_cmd_valid"}, n_cmd - s_cmd, e_cmd);
    check({tag, "_error"}, n_err - s_err, e_err);
    check({tag, "_width"}, int'(bus.width), exp_width);
    check({tag, "_locked"}, int'(bus.locked), exp_locked);
  endtask

  task automatic run_pulse(input int n, input int low, input string tag);
    snap();
    model(n);
    hold(1'b1, n);
    hold(1'b0, low);
    verify(tag);
  endtask

  initial begin
    int n;
    int sel;
    int base;
    int bnd[6];

    bus.pwm_in = 1'b0;
    rst = 1'b1;
    exp_width = 0;
    exp_locked = 0;
    repeat (5) @(negedge clk);
    check("rst_width", int'(bus.width), 0);
    check("rst_width_valid", int'(bus.width_valid), 0);
    check("rst_locked", int'(bus.locked), 0);
    check("rst_cmd_valid", int'(bus.cmd_valid), 0);
    check("rst_error", int'(bus.error), 0);
    check("rst_timeout", int'(bus.timeout), 0);
    rst = 1'b0;
    hold(1'b0, 50);

    // Nominal and boundary pulses.
    run_pulse(T_LOCK + 1, 500, "lock1");
    run_pulse(T_LOCK + 1, 500, "lock2");
    run_pulse(T_UNLOCK + 1, 500, "unlock1");
    run_pulse(T_LOCK + T_TOL, 400, "lock_tol_hi");
    run_pulse(T_LOCK + T_TOL + 1, 400, "lock_tol_out");
    run_pulse(T_UNLOCK - T_TOL, 400, "unlock_tol_lo");
    run_pulse(T_UNLOCK - T_TOL - 1, 400, "unlock_tol_out");
    run_pulse(750, 400, "mid_error");
    run_pulse(T_MAX, 400, "max_exact");

    // Glitches on a low line leave everything untouched.
    snap();
    e_wv = 0; e_cmd = 0; e_err = 0;
    hold(1'b1, 1); hold(1'b0, 20);
    hold(1'b1, 2); hold(1'b0, 20);
    hold(1'b1, 3); hold(1'b0, 200);
    verify("glitch");

    // A short dip inside a pulse is filtered: seen as one 504-cycle pulse.
    snap();
    model(504);
    hold(1'b1, 200); hold(1'b0, 3); hold(1'b1, 301); hold(1'b0, 400);
    verify("dip");

    // Stuck-high pulse: error MAX cycles after the filtered rise, no width.
    run_pulse(T_MAX + 50, 400, "stuck");
    check("stuck_err_time", last_err_cyc - rise_cyc, int'(T_MAX) + 2 + int'(T_FLEN));
    run_pulse(T_LOCK + 1, 400, "after_stuck");

    // Randomized pulses.
    bnd[0] = T_LOCK - T_TOL;     bnd[1] = T_LOCK - T_TOL - 1;
    bnd[2] = T_UNLOCK + T_TOL;   bnd[3] = T_UNLOCK + T_TOL + 1;
    bnd[4] = T_MIN - 1;          bnd[5] = T_MAX + 1;
    for (int k = 0; k < 12; k++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: begin base = T_LOCK - T_TOL;   n = base + int'($urandom_range(0, 2 * T_TOL)); end
        1: begin base = T_UNLOCK - T_TOL; n = base + int'($urandom_range(0, 2 * T_TOL)); end
        2: n = int'($urandom_range(100, 1400));
        default: n = bnd[$urandom_range(0, 5)];
      endcase
      run_pulse(n, int'($urandom_range(300, 600)), $sformatf("rand%0d_n%0d", k, n));
    end

    // Dead line: timeout rises exactly when the period counter saturates.
    run_pulse(T_UNLOCK + 1, 300, "pre_timeout");
    check("timeout_low", int'(bus.timeout), 0);
    while (cyc < rise_cyc + int'(T_TO) + 30) begin
      @(negedge clk);
      if (cyc == rise_cyc + int'(T_TO) + 1 + int'(T_FLEN))
        check("timeout_pre_sat", int'(bus.timeout), 0);
      if (cyc == rise_cyc + int'(T_TO) + 2 + int'(T_FLEN))
        check("timeout_at_sat", int'(bus.timeout), 1);
    end
    check("timeout_held", int'(bus.timeout), 1);
    check("timeout_locked_hold", int'(bus.locked), 0);
    run_pulse(T_LOCK + 1, 400, "after_timeout");
    check("timeout_cleared", int'(bus.timeout), 0);

    // Reset in the middle of a pulse; the tail must not be decoded.
    hold(1'b1, 200);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_width", int'(bus.width), 0);
    check("midrst_locked", int'(bus.locked), 0);
    check("midrst_timeout", int'(bus.timeout), 0);
    hold(1'b1, 10);
    rst = 1'b0;
    exp_width = 0;
    exp_locked = 0;
    snap();
    e_wv = 0; e_cmd = 0; e_err = 0;
    hold(1'b1, 300);
    hold(1'b0, 400);
    verify("midrst_tail");
    run_pulse(T_LOCK + 1, 400, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
